btn_debounce: RTL

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 83 ++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Per-channel button debouncer: 2-flop synchronizer, stability counter, level plus press/release pulses.
// Latency 2+STABLE_CYCLES edges from a held input change to the level/pulse outputs; no backpressure, free-running.
module btn_debounce #(
  parameter int FREQUENCY   = 50*10**6,
  parameter int DEBOUNCE_MS = 10,
  parameter int WIDTH       = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level_out,
  output logic [WIDTH-1:0] btn_press_out,
  output logic [WIDTH-1:0] btn_release_out
);

  localparam int RAW_CYCLES    = (FREQUENCY / 1000) * DEBOUNCE_MS;
  localparam int STABLE_CYCLES = (RAW_CYCLES < 1) ? 1 : RAW_CYCLES;
  localparam int CNT_CLOG      = $clog2(STABLE_CYCLES + 1);
  localparam int CNT_W         = (CNT_CLOG < 1) ? 1 : CNT_CLOG;

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RELEASED_RAW = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_release;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_norm;
  logic [WIDTH-1:0] w_differ;
  logic [WIDTH-1:0] w_done;

  assign w_norm   = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;
  assign w_differ = w_norm ^ r_stable;

  // A channel commits when it has disagreed with stable for STABLE_CYCLES consecutive edges.
  always_comb begin
    w_done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_done[i] = w_differ[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1 <= RELEASED_RAW;
      r_s2 <= RELEASED_RAW;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable  <= r_stable ^ w_done;
      r_press   <= w_done & w_norm;
      r_release <= w_done & ~w_norm;
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_differ[i] || w_done[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level_out   = r_stable;
  assign btn_press_out   = r_press;
  assign btn_release_out = r_release;

endmodule
